// File: rtl/dmem_pkg.sv
// Shared definitions for the CPU data-memory responder.
// Holds the loader FSM state encoding, default widths and the MMIO address map.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W      = 5;
  localparam int unsigned DMEM_DATA_W      = 8;
  localparam int unsigned DMEM_IO_IN_ADDR  = 30;
  localparam int unsigned DMEM_IO_OUT_ADDR = 31;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_LOAD = 1'b1
  } dmem_state_e;

endpackage : dmem_pkg

// File: rtl/dmem_load_fsm.sv
// Bulk-load sequencer for the data memory.
// The CPU is held while exactly 2**ADDR_W beats are written from address 0 upward.
// Ports:
//   clk, rst     clock and synchronous active-low reset
//   ld_start     pulse that begins a load (ignored while loading)
//   ld_valid     loader beat valid
//   ld_cnt       word address of the next loader beat
//   ld_ready     registered, high while loading
//   cpu_hold     registered, high while loading
//   ld_sel_c     write/read mux select: loader owns the RAM port
//   ld_we_c      loader write enable for this cycle
module dmem_load_fsm
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic [ADDR_W-1:0] ld_cnt,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic              ld_sel_c,
  output logic              ld_we_c
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  dmem_state_e       state;
  dmem_state_e       state_nxt;
  logic [ADDR_W-1:0] cnt_nxt;

  // State register; hold/ready follow the next state so they change with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_RUN;
      ld_cnt   <= '0;
      ld_ready <= 1'b0;
      cpu_hold <= 1'b0;
    end else begin
      state    <= state_nxt;
      ld_cnt   <= cnt_nxt;
      ld_ready <= (state_nxt == S_LOAD);
      cpu_hold <= (state_nxt == S_LOAD);
    end
  end

  // Next-state and beat counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = ld_cnt;
    case (state)
      S_RUN: begin
        if (ld_start) begin
          state_nxt = S_LOAD;
          cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          if (ld_cnt == LAST_IDX) begin
            state_nxt = S_RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = ld_cnt + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_nxt = S_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    ld_sel_c = 1'b0;
    ld_we_c  = 1'b0;
    if (state == S_LOAD) begin
      ld_sel_c = 1'b1;
      ld_we_c  = ld_valid;
    end
  end

endmodule : dmem_load_fsm

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory bus: DEPTH x DATA_W RAM with
// zero-latency reads, a streaming loader that holds the CPU while it fills
// the RAM, and optional memory-mapped I/O enabled by defining DMEM_MMIO_EN.
// Ports:
//   clk, rst           clock and synchronous active-low reset
//   mem_rd, mem_wr     CPU read / write strobes
//   mem_in_addr_bus    CPU address
//   mem_in_data_bus    CPU write data
//   mem_out_data_bus   combinational read data to CPU (0 when not reading or loading)
//   ld_start           begin bulk load from address 0
//   ld_valid, ld_data  loader beat
//   ld_ready           loader beat accepted when ld_valid & ld_ready
//   cpu_hold           high while loading
//   io_in              external input, asynchronous to clk
//   io_out             external output register (0 without DMEM_MMIO_EN)
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DMEM_ADDR_W,
  parameter int unsigned DATA_W      = DMEM_DATA_W,
  parameter int unsigned IO_IN_ADDR  = DMEM_IO_IN_ADDR,
  parameter int unsigned IO_OUT_ADDR = DMEM_IO_OUT_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_in_addr_bus,
  input  logic [DATA_W-1:0] mem_in_data_bus,
  output logic [DATA_W-1:0] mem_out_data_bus,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              cpu_hold,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] ram [DEPTH];

  logic [ADDR_W-1:0] ld_cnt;
  logic              ld_sel_c;
  logic              ld_we_c;
  logic              cpu_wr_c;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_waddr_c;
  logic [DATA_W-1:0] ram_wdata_c;

  dmem_load_fsm #(
    .ADDR_W (ADDR_W)
  ) u_load_fsm (
    .clk      (clk),
    .rst      (rst),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_cnt   (ld_cnt),
    .ld_ready (ld_ready),
    .cpu_hold (cpu_hold),
    .ld_sel_c (ld_sel_c),
    .ld_we_c  (ld_we_c)
  );

`ifdef DMEM_MMIO_EN
  localparam logic [ADDR_W-1:0] IN_ADDR  = ADDR_W'(IO_IN_ADDR);
  localparam logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(IO_OUT_ADDR);

  logic              is_io_in_c;
  logic              is_io_out_c;
  logic [DATA_W-1:0] io_sync1;
  logic [DATA_W-1:0] io_sync2;

  assign is_io_in_c  = (mem_in_addr_bus == IN_ADDR);
  assign is_io_out_c = (mem_in_addr_bus == OUT_ADDR);

  // CPU writes to either I/O address never reach the RAM.
  assign cpu_wr_c = mem_wr & ~ld_sel_c & ~is_io_in_c & ~is_io_out_c;

  // Output port register and two-flop input synchroniser.
  always_ff @(posedge clk) begin
    if (!rst) begin
      io_out   <= '0;
      io_sync1 <= '0;
      io_sync2 <= '0;
    end else begin
      io_sync1 <= io_in;
      io_sync2 <= io_sync1;
      if (mem_wr && !ld_sel_c && is_io_out_c) begin
        io_out <= mem_in_data_bus;
      end
    end
  end
`else
  logic io_unused;

  assign cpu_wr_c  = mem_wr & ~ld_sel_c;
  assign io_out    = '0;
  assign io_unused = ^{io_in, ADDR_W'(IO_IN_ADDR), ADDR_W'(IO_OUT_ADDR)};
`endif

  // RAM write port: loader owns it while loading, CPU otherwise.
  always_comb begin
    ram_we_c    = cpu_wr_c;
    ram_waddr_c = mem_in_addr_bus;
    ram_wdata_c = mem_in_data_bus;
    if (ld_sel_c) begin
      ram_we_c    = ld_we_c;
      ram_waddr_c = ld_cnt;
      ram_wdata_c = ld_data;
    end
  end

  // RAM contents survive reset; only writes in the reset cycle are blocked.
  always_ff @(posedge clk) begin
    if (rst && ram_we_c) begin
      ram[ram_waddr_c] <= ram_wdata_c;
    end
  end

  // Zero-latency read; a same-cycle write to the same word lands at the edge.
  always_comb begin
    mem_out_data_bus = '0;
    if (mem_rd && !ld_sel_c) begin
      mem_out_data_bus = ram[mem_in_addr_bus];
`ifdef DMEM_MMIO_EN
      if (is_io_in_c) begin
        mem_out_data_bus = io_sync2;
      end else if (is_io_out_c) begin
        mem_out_data_bus = io_out;
      end
`endif
    end
  end

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

  logic       clk;
  logic       rst;
  logic       mem_rd;
  logic       mem_wr;
  logic [4:0] mem_in_addr_bus;
  logic [7:0] mem_in_data_bus;
  logic [7:0] mem_out_data_bus;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       cpu_hold;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int checks   = 0;
  int failures = 0;

  data_mem_responder dut (
    .clk              (clk),
    .rst              (rst),
    .mem_rd           (mem_rd),
    .mem_wr           (mem_wr),
    .mem_in_addr_bus  (mem_in_addr_bus),
    .mem_in_data_bus  (mem_in_data_bus),
    .mem_out_data_bus (mem_out_data_bus),
    .ld_start         (ld_start),
    .ld_valid         (ld_valid),
    .ld_data          (ld_data),
    .ld_ready         (ld_ready),
    .cpu_hold         (cpu_hold),
    .io_in            (io_in),
    .io_out           (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [4:0] addr, input logic [7:0] exp);
    mem_rd          = 1'b1;
    mem_in_addr_bus = addr;
    #1;
    check(tag, mem_out_data_bus, exp);
    mem_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b0;
    mem_rd          = 1'b0;
    mem_wr          = 1'b0;
    mem_in_addr_bus = '0;
    mem_in_data_bus = '0;
    ld_start        = 1'b0;
    ld_valid        = 1'b0;
    ld_data         = '0;
    io_in           = '0;

    repeat (3) step();
    check("rst_cpu_hold", 8'(cpu_hold), 8'h00);
    check("rst_ld_ready", 8'(ld_ready), 8'h00);
    check("rst_io_out", io_out, 8'h00);
    check("rst_bus_idle", mem_out_data_bus, 8'h00);
    rst = 1'b1;
    step();

    // Basic write then read; idle bus reads zero.
    mem_wr = 1'b1; mem_in_addr_bus = 5'd3; mem_in_data_bus = 8'hA5;
    step();
    mem_wr = 1'b0;
    read_chk("rd_after_wr_3", 5'd3, 8'hA5);
    #1;
    check("rd_idle_zero", mem_out_data_bus, 8'h00);

`ifdef DMEM_MMIO_EN
    step();
    mem_wr = 1'b1; mem_in_addr_bus = 5'd31; mem_in_data_bus = 8'h5C;
    step();
    mem_wr = 1'b0;
    #1;
    check("mmio_io_out", io_out, 8'h5C);
    read_chk("mmio_rd_out", 5'd31, 8'h5C);
    io_in = 8'h3E;
    step();
    read_chk("mmio_in_1cyc", 5'd30, 8'h00);
    step();
    read_chk("mmio_in_2cyc", 5'd30, 8'h3E);
`else
    step();
    mem_wr = 1'b1; mem_in_addr_bus = 5'd31; mem_in_data_bus = 8'h5C;
    step();
    mem_wr = 1'b0;
    read_chk("plain_rd_31", 5'd31, 8'h5C);
    check("plain_io_out", io_out, 8'h00);
`endif

    // Full load with 3-cycle gaps; a CPU write during the load is ignored.
    step();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    #1;
    check("ld_hold_rise", 8'(cpu_hold), 8'h01);
    check("ld_ready_rise", 8'(ld_ready), 8'h01);
    for (int i = 0; i < 32; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(i) ^ 8'hFF;
      if (i == 4) begin
        mem_wr = 1'b1; mem_in_addr_bus = 5'd4; mem_in_data_bus = 8'h11;
        mem_rd = 1'b1;
        #1;
        check("ld_bus_forced0", mem_out_data_bus, 8'h00);
      end
      if (i == 31) begin
        #1;
        check("ld_hold_last_beat", 8'(cpu_hold), 8'h01);
      end
      step();
      ld_valid = 1'b0;
      mem_wr   = 1'b0;
      mem_rd   = 1'b0;
      if (i != 31) begin
        check("ld_hold_gap", 8'(cpu_hold), 8'h01);
        repeat (3) step();
      end
    end
    check("ld_hold_fall", 8'(cpu_hold), 8'h00);
    check("ld_ready_fall", 8'(ld_ready), 8'h00);
    read_chk("ld_rd_7", 5'd7, 8'hF8);
    read_chk("ld_rd_4_no_cpu_wr", 5'd4, 8'hFB);
    read_chk("ld_rd_0", 5'd0, 8'hFF);
    read_chk("ld_rd_3", 5'd3, 8'hFC);
`ifndef DMEM_MMIO_EN
    read_chk("ld_rd_31", 5'd31, 8'hE0);
`endif

    // Same-cycle read and write: old value now, new value next cycle.
    step();
    mem_wr = 1'b1; mem_in_addr_bus = 5'd9; mem_in_data_bus = 8'h22;
    step();
    mem_in_data_bus = 8'h33;
    mem_rd = 1'b1;
    #1;
    check("rdwr_old", mem_out_data_bus, 8'h22);
    step();
    mem_wr = 1'b0;
    #1;
    check("rdwr_new", mem_out_data_bus, 8'h33);
    mem_rd = 1'b0;

    // Reset after beat 10 of a second load.
    step();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(i) ^ 8'h55;
      step();
    end
    ld_valid = 1'b0;
    check("mid_hold_before_rst", 8'(cpu_hold), 8'h01);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_hold", 8'(cpu_hold), 8'h00);
    check("mid_rst_ready", 8'(ld_ready), 8'h00);
    read_chk("mid_rd_0", 5'd0, 8'h55);
    read_chk("mid_rd_9", 5'd9, 8'h5C);
    read_chk("mid_rd_10", 5'd10, 8'h5F);
    read_chk("mid_rd_11_old", 5'd11, 8'hF4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_data_mem_responder
